alu: RTL and testbench
======================

Name: alu

Overview:
- Single-cycle registered 32-bit arithmetic/logic unit with a 33-bit result (bit 32 = carry/borrow/shift-out).
- Operates on 32-bit operands a and b under a 3-bit opcode.
- The operation is accepted when en is high at a rising clock edge. The registered result is presented one cycle later, together with a one-cycle ack strobe.
- Sits as a datapath leaf under a controller that drives en/opcode and consumes result on ack.

Parameters:
- WIDTH, 32, operand width; result width is WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- result  output  33  registered operation result; bit 32 is the extension bit
- a  input  32  operand A (unsigned)
- b  input  32  operand B (unsigned; b[4:0] is the shift amount for shifts)
- opcode  input  3  operation select
- en  input  1  operation request, sampled at each rising clk edge
- ack  output  1  high for the cycle in which result holds the response to the previous en

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset: on a rising edge with rst=1, result<=0 and ack<=0. rst dominates en; a request present in the same edge is discarded.
- Request: on a rising edge with rst=0 and en=1, result<=f(opcode,a,b) and ack<=1.
- Latency is 1 cycle; back-to-back requests (en held high) give one result per cycle, each reflecting the inputs sampled at its own edge.
- Idle: on a rising edge with rst=0 and en=0, result holds its previous value and ack<=0.
- Inputs are sampled only at edges; changes between edges have no effect. The operation is purely combinational internally, with no multi-cycle state.
- Opcode map (R = 33-bit result; unsigned arithmetic):
  - 000 ADD: R = {1'b0,a} + {1'b0,b}; bit 32 = carry out.
  - 001 SUB: R = {1'b0,a} - {1'b0,b} modulo 2^33; bit 32 = 1 exactly when a < b (borrow).
  - 010 AND: R = {1'b0, a & b}.
  - 011 OR: R = {1'b0, a | b}.
  - 100 XOR: R = {1'b0, a ^ b}.
  - 101 NOT: R = {1'b0, ~a}; b ignored.
  - 110 SHL: R = ({1'b0,a} << b[4:0]) truncated to 33 bits; bit 32 = last bit shifted out of a (0 when shift is 0).
  - 111 SHR: R = {1'b0, a >> b[4:0]} (logical, zero fill).
  - b[31:5] are ignored for shifts.
- No X propagation: every opcode value is defined, so no default or illegal case exists.
- Reset mid-stream: a reset asserted while en is high clears result and ack on that edge. Operation resumes on the first edge with rst=0 and en=1.

Test Plan:
- rst=1 for 2 edges with en=1, a=13, b=5 -> result=0 and ack=0 after each edge. Release rst with en=0 -> result stays 0, ack=0.
- a=13, b=5, en=1, opcode stepped 000..111 one per cycle -> results in order 18, 8, 5, 13, 8, 33'h0_FFFFFFF2, 416, 0. ack=1 on every result cycle.
- ADD a=32'hFFFFFFFF, b=1 -> result=33'h1_00000000. SUB a=5, b=13 -> result=33'h1_FFFFFFF8 (borrow set).
- SHL a=32'h80000001, b=1 -> result=33'h1_00000002. SHL with b=32 (b[4:0]=0) -> result={1'b0,a}. SHR a=32'h80000000, b=31 -> result=1.
- en pulse for one cycle (ADD 13+5), then en=0 with a, b and opcode changed -> result holds 18 on later edges. ack is high for exactly one cycle.
- en held high; rst asserted for one edge mid-stream -> that edge yields result=0, ack=0. The next edge computes normally with ack=1.

Source files
------------

// File: rtl/alu.sv
// Registered 32-bit ALU: one operation per enabled clock edge, result and ack one cycle later.
// Bit WIDTH of the result carries carry, borrow or the last bit shifted out on a left shift.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_opcode,
    input  logic             i_en,
    output logic [WIDTH:0]   o_result,
    output logic             o_ack
);

    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [ShW-1:0]   w_shamt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH:0]   w_func;

    logic [WIDTH:0]   r_result;
    logic             r_ack;

    assign w_a_ext = {1'b0, i_a};
    assign w_b_ext = {1'b0, i_b};
    // Only the low bits select the shift distance; upper operand bits are ignored.
    assign w_shamt = i_b[ShW-1:0];

    // The extra top bit captures carry out, borrow (a < b) and the left-shift spill bit.
    assign w_add = w_a_ext + w_b_ext;
    assign w_sub = w_a_ext - w_b_ext;
    assign w_shl = w_a_ext << w_shamt;
    assign w_shr = i_a >> w_shamt;

    always_comb begin
        w_func = '0;
        unique case (i_opcode)
            OpAdd: w_func = w_add;
            OpSub: w_func = w_sub;
            OpAnd: w_func = {1'b0, i_a & i_b};
            OpOr:  w_func = {1'b0, i_a | i_b};
            OpXor: w_func = {1'b0, i_a ^ i_b};
            OpNot: w_func = {1'b0, ~i_a};
            OpShl: w_func = w_shl;
            OpShr: w_func = {1'b0, w_shr};
        endcase
    end

    // Reset wins over a coincident request; idle edges hold the last result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
            r_ack    <= 1'b0;
        end else if (i_en) begin
            r_result <= w_func;
            r_ack    <= 1'b1;
        end else begin
            r_ack    <= 1'b0;
        end
    end

    assign o_result = r_result;
    assign o_ack    = r_ack;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences for hold/reset corners,
// then random traffic against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic        en;
    logic [32:0] result;
    logic        ack;

    int n_tests;
    int n_fail;

    alu #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a     (a),
        .i_b     (b),
        .i_opcode(opcode),
        .i_en    (en),
        .o_result(result),
        .o_ack   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp_result;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[16];

    // Reference: plain 64-bit arithmetic reduced modulo 2^33.
    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] xa,
                                            input logic [31:0] xb);
        longint unsigned la;
        longint unsigned lb;
        longint unsigned r;
        int              sh;
        la = 64'(xa);
        lb = 64'(xb);
        sh = int'(xb % 32);
        case (op)
            3'd0:    r = la + lb;
            3'd1:    r = la - lb;
            3'd2:    r = la & lb;
            3'd3:    r = la | lb;
            3'd4:    r = la ^ lb;
            3'd5:    r = 64'hFFFF_FFFF - la;
            3'd6:    r = la << sh;
            default: r = la >> sh;
        endcase
        return r[32:0];
    endfunction

    task automatic check(input string name, input logic [32:0] exp_r, input logic exp_a);
        n_tests++;
        if (result !== exp_r || ack !== exp_a) begin
            n_fail++;
            $display("FAIL %s: result=%h ack=%b, expected result=%h ack=%b",
                     name, result, ack, exp_r, exp_a);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] op,
                         input logic [31:0] va, input logic [31:0] vb);
        rst    = r;
        en     = e;
        opcode = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
    endtask

    logic [32:0] m_result;
    logic        m_ack;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b1; opcode = 3'd0; a = 32'd13; b = 32'd5;

        vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'd13, 32'd5, 33'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'd13, 32'd5, 33'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 32'd13, 32'd5, 33'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 32'd13, 32'd5, 33'd18, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 32'd13, 32'd5, 33'd8, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'd2, 32'd13, 32'd5, 33'd5, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 3'd3, 32'd13, 32'd5, 33'd13, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 32'd13, 32'd5, 33'd8, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 3'd5, 32'd13, 32'd5, 33'h0_FFFF_FFF2, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd6, 32'd13, 32'd5, 33'd416, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 3'd7, 32'd13, 32'd5, 33'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'd1, 32'd5, 32'd13, 33'h1_FFFF_FFF8, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'd6, 32'h8000_0001, 32'd1, 33'h1_0000_0002, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 3'd6, 32'h1234_5678, 32'd32, 33'h0_1234_5678, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 3'd7, 32'h8000_0000, 32'd31, 33'd1, 1'b1};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_ack);
        end

        // Single-cycle en pulse: result must hold while inputs wander.
        drive(1'b0, 1'b1, 3'd0, 32'd13, 32'd5);
        check("pulse_add", 33'd18, 1'b1);
        drive(1'b0, 1'b0, 3'd1, 32'd7, 32'd99);
        check("pulse_hold1", 33'd18, 1'b0);
        drive(1'b0, 1'b0, 3'd5, 32'hDEAD_BEEF, 32'd3);
        check("pulse_hold2", 33'd18, 1'b0);

        // Reset mid-stream with en held high.
        drive(1'b0, 1'b1, 3'd0, 32'd1, 32'd2);
        check("stream_pre", 33'd3, 1'b1);
        drive(1'b1, 1'b1, 3'd0, 32'd4, 32'd4);
        check("stream_rst", 33'd0, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 32'd4, 32'd4);
        check("stream_resume", 33'd8, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 32'd9, 32'd9);
        check("stream_idle", 33'd8, 1'b0);

        // Random traffic against the reference model.
        m_result = 33'd8;
        m_ack    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        r_r;
            logic        r_e;
            logic [2:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_r  = ($urandom_range(0, 15) == 0);
            r_e  = ($urandom_range(0, 3) != 0);
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_a = 32'hFFFF_FFFF;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_a = r_b;
                default: ;
            endcase
            drive(r_r, r_e, r_op, r_a, r_b);
            if (r_r) begin
                m_result = 33'd0;
                m_ack    = 1'b0;
            end else if (r_e) begin
                m_result = ref_alu(r_op, r_a, r_b);
                m_ack    = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
            check($sformatf("rand%0d_op%0d", i, r_op), m_result, m_ack);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
